// File: rtl/dcache_axi_req_queue_pkg.sv
// Shared request-entry layout and AXI encodings for the dcache AXI request queue.
package dcache_axi_req_queue_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int CNT_W  = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [1:0]        burst;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_entry_t;

  localparam int ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/dcache_axi_req_fifo.sv
// Generic synchronous FIFO; head data is read straight from storage, so no push-to-pop bypass.
module dcache_axi_req_fifo #(
  parameter int WIDTH = 83,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap through natural overflow of the log2(DEPTH)-bit registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dcache_axi_req_queue.sv
// Dcache request queue in front of the AXI splitter: buffers requests/beats and caps outstanding
// transactions. Optional macro DCACHE_AXI_REQ_ORDER_EN holds reads while writes are outstanding.
module dcache_axi_req_queue
  import dcache_axi_req_queue_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [ID_W-1:0]   req_id_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic [1:0]        req_burst_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [STRB_W-1:0] req_wstrb_i,
  output logic              req_accept_o,
  output logic              outport_valid_o,
  output logic              outport_write_o,
  output logic [ADDR_W-1:0] outport_addr_o,
  output logic [ID_W-1:0]   outport_id_o,
  output logic [LEN_W-1:0]  outport_len_o,
  output logic [1:0]        outport_burst_o,
  output logic [DATA_W-1:0] outport_wdata_o,
  output logic [STRB_W-1:0] outport_wstrb_o,
  input  logic              outport_accept_i,
  input  logic              axi_bvalid_i,
  input  logic              axi_bready_i,
  input  logic              axi_rvalid_i,
  input  logic              axi_rready_i,
  input  logic              axi_rlast_i,
  output logic              idle_o
);

  req_entry_t       in_ent, head;
  logic             full, empty, pop;
  logic [LEN_W-1:0] wr_beats_q, wr_beats_d;
  logic [CNT_W-1:0] wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic [CNT_W:0]   outstanding;
  logic             head_first, at_limit, order_mask, throttle;
  logic             wr_inc, rd_inc, b_ret, r_ret;

  assign in_ent = '{write: req_write_i, addr: req_addr_i, id: req_id_i, len: req_len_i,
                    burst: req_burst_i, wdata: req_wdata_i, wstrb: req_wstrb_i};

  dcache_axi_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (req_valid_i),
    .data_i  (in_ent),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign req_accept_o = !full;

  // Only transaction heads open a new AXI transaction, so only they are throttled.
  assign head_first  = !head.write || (wr_beats_q == '0);
  assign outstanding = {1'b0, wr_out_q} + {1'b0, rd_out_q};
  assign at_limit    = (outstanding == (CNT_W+1)'(MAX_OUTSTANDING));

`ifdef DCACHE_AXI_REQ_ORDER_EN
  assign order_mask = !head.write && (wr_out_q != '0);
`else
  assign order_mask = 1'b0;
`endif

  assign throttle        = (head_first && at_limit) || order_mask;
  assign outport_valid_o = !empty && !throttle;
  assign pop             = outport_valid_o && outport_accept_i;

  assign outport_write_o = head.write;
  assign outport_addr_o  = head.addr;
  assign outport_id_o    = head.id;
  assign outport_len_o   = head.len;
  assign outport_burst_o = head.burst;
  assign outport_wdata_o = head.wdata;
  assign outport_wstrb_o = head.wstrb;

  assign wr_inc = pop && head.write && (wr_beats_q == '0);
  assign rd_inc = pop && !head.write;
  assign b_ret  = axi_bvalid_i && axi_bready_i;
  assign r_ret  = axi_rvalid_i && axi_rready_i && axi_rlast_i;

  always_comb begin
    wr_beats_d = wr_beats_q;
    wr_out_d   = wr_out_q;
    rd_out_d   = rd_out_q;
    if (pop && head.write)
      wr_beats_d = (wr_beats_q == '0) ? head.len : wr_beats_q - 1'b1;
    if (wr_inc && !b_ret)      wr_out_d = wr_out_q + 1'b1;
    else if (!wr_inc && b_ret) wr_out_d = wr_out_q - 1'b1;
    if (rd_inc && !r_ret)      rd_out_d = rd_out_q + 1'b1;
    else if (!rd_inc && r_ret) rd_out_d = rd_out_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_beats_q <= '0;
      wr_out_q   <= '0;
      rd_out_q   <= '0;
    end else begin
      wr_beats_q <= wr_beats_d;
      wr_out_q   <= wr_out_d;
      rd_out_q   <= rd_out_d;
    end
  end

  assign idle_o = empty && (wr_out_q == '0) && (rd_out_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(b_ret && !wr_inc && wr_out_q == '0)) else $error("wr_out underflow");
      assert (!(r_ret && !rd_inc && rd_out_q == '0)) else $error("rd_out underflow");
    end
  end

endmodule

// File: tb/tb_dcache_axi_req_queue.sv
// Directed bench for dcache_axi_req_queue (DEPTH=4, MAX_OUTSTANDING=2); ORDER_EN expectations
// follow the DCACHE_AXI_REQ_ORDER_EN macro.
module tb_dcache_axi_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_accept;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_id, req_wstrb;
  logic [7:0]  req_len;
  logic [1:0]  req_burst;
  logic        o_valid, o_write, o_accept;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_id, o_wstrb;
  logic [7:0]  o_len;
  logic [1:0]  o_burst;
  logic        bvalid, bready, rvalid, rready, rlast, idle;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] tb_beats = '0;

  always #5 clk = ~clk;

  dcache_axi_req_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_id_i(req_id), .req_len_i(req_len), .req_burst_i(req_burst),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb), .req_accept_o(req_accept),
    .outport_valid_o(o_valid), .outport_write_o(o_write), .outport_addr_o(o_addr),
    .outport_id_o(o_id), .outport_len_o(o_len), .outport_burst_o(o_burst),
    .outport_wdata_o(o_wdata), .outport_wstrb_o(o_wstrb), .outport_accept_i(o_accept),
    .axi_bvalid_i(bvalid), .axi_bready_i(bready),
    .axi_rvalid_i(rvalid), .axi_rready_i(rready), .axi_rlast_i(rlast),
    .idle_o(idle)
  );

  // Upstream rule: a read never pops in the middle of a write burst.
  always @(posedge clk) begin
    if (rst) tb_beats <= '0;
    else if (o_valid && o_accept) begin
      assert (o_write || tb_beats == 0) else $error("read popped mid-burst");
      if (o_write) tb_beats <= (tb_beats == 0) ? o_len : tb_beats - 8'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [7:0] len, input logic [31:0] d);
    req_valid = v; req_write = w; req_addr = a; req_len = len; req_wdata = d;
    req_id = 4'h2; req_burst = 2'b01; req_wstrb = 4'hF;
  endtask

  task automatic set_b(input logic v);
    bvalid = v; bready = v;
  endtask

  task automatic set_r(input logic v);
    rvalid = v; rready = v; rlast = v;
  endtask

  initial begin
    rst = 1'b1; o_accept = 1'b0;
    drive(0, 0, 0, 0, 0); set_b(0); set_r(0);

    // 1: reset
    repeat (2) tick();
    rst = 1'b0; #1;
    check("rst_valid", o_valid, 0);
    check("rst_accept", req_accept, 1);
    check("rst_idle", idle, 1);

    // 2: 4-beat write burst, accept tied high
    o_accept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h1000, 8'd3, 32'hA0 + i); #1;
      if (i > 0) begin
        check("wb_valid", o_valid, 1);
        check("wb_data", o_wdata, 32'hA0 + i - 1);
      end
      if (i == 1) check("wb_len", o_len, 3);
      tick();
    end
    drive(0, 0, 0, 0, 0); #1;
    check("wb_last_valid", o_valid, 1);
    check("wb_last_data", o_wdata, 32'hA3);
    tick();
    check("wb_empty_valid", o_valid, 0);
    check("wb_busy", idle, 0);
    set_b(1); tick(); set_b(0); #1;
    check("wb_idle", idle, 1);

    // 3: fill with downstream stalled, then one pop
    o_accept = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h300 + 4*i, 0, 0); #1;
      check("fill_accept", req_accept, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0); #1;
    check("full_accept", req_accept, 0);
    check("full_head", o_addr, 32'h300);
    o_accept = 1'b1; tick(); o_accept = 1'b0; #1;
    check("pop_accept", req_accept, 1);
    o_accept = 1'b1; set_r(1);
    for (int i = 1; i < 4; i++) begin
      #1;
      check("drain_valid", o_valid, 1);
      check("drain_addr", o_addr, 32'h300 + 4*i);
      tick();
    end
    check("drain_empty", o_valid, 0);
    tick(); set_r(0); #1;
    check("drain_idle", idle, 1);

    // 4: outstanding limit of 2 masks the third read
    drive(1, 0, 32'h400, 0, 0); tick();
    drive(1, 0, 32'h404, 0, 0); #1;
    check("lim_r0", o_addr, 32'h400);
    tick();
    drive(1, 0, 32'h408, 0, 0); #1;
    check("lim_r1", o_addr, 32'h404);
    tick();
    drive(0, 0, 0, 0, 0); #1;
    check("lim_mask", o_valid, 0);
    tick();
    check("lim_mask2", o_valid, 0);
    set_r(1); #1;
    check("lim_mask_r", o_valid, 0);
    tick(); set_r(0); #1;
    check("lim_release", o_valid, 1);
    check("lim_r2", o_addr, 32'h408);
    tick();
    check("lim_empty", o_valid, 0);
    set_r(1); repeat (2) tick(); set_r(0); #1;
    check("lim_idle", idle, 1);

    // 5: burst beats are not masked at the limit
    drive(1, 0, 32'h500, 0, 0); tick();
    drive(1, 1, 32'h600, 8'd1, 32'hB0); #1;
    check("mb_read", o_write, 0);
    tick();
    drive(1, 1, 32'h600, 8'd1, 32'hB1); #1;
    check("mb_head_valid", o_valid, 1);
    check("mb_head_data", o_wdata, 32'hB0);
    tick();
    drive(0, 0, 0, 0, 0); #1;
    check("mb_beat_valid", o_valid, 1);
    check("mb_beat_data", o_wdata, 32'hB1);
    tick();
    check("mb_busy", idle, 0);
    set_b(1); set_r(1); tick(); set_b(0); set_r(0); #1;
    check("mb_idle", idle, 1);

    // 6: read behind an outstanding write
    drive(1, 1, 32'h700, 0, 32'hC0); tick();
    drive(1, 0, 32'h800, 0, 0); #1;
    check("ord_wr", o_write, 1);
    tick();
    drive(0, 0, 0, 0, 0); o_accept = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
`ifdef DCACHE_AXI_REQ_ORDER_EN
      check("ord_hold", o_valid, 0);
`else
      check("ord_free", o_valid, 1);
`endif
      tick();
    end
    set_b(1); tick(); set_b(0); #1;
    check("ord_after_b", o_valid, 1);
    check("ord_addr", o_addr, 32'h800);
    o_accept = 1'b1; tick(); o_accept = 1'b0;
    set_r(1); tick(); set_r(0); #1;
    check("ord_idle", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
